// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV32I control units: FSM states, opcode/funct fields,
// datapath select codes and the per-state control word.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_LUI    = 4'd9,
        S_ALUWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JAL    = 4'd12,
        S_JALR   = 4'd13,
        S_ERROR  = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_RFUNCT, ALUOP_IFUNCT} aluop_t;
    typedef enum logic [1:0] {SRCA_PC, SRCA_RS1, SRCA_ZERO} srca_t;
    typedef enum logic [1:0] {SRCB_RS2, SRCB_FOUR, SRCB_IMM} srcb_t;
    typedef enum logic [1:0] {WB_ALUOUT, WB_MDR, WB_PC} memtoreg_t;
    typedef enum logic [1:0] {PCSRC_ALU, PCSRC_ALUOUT} pcsrc_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_LOAD, CLS_STORE, CLS_RTYPE, CLS_ITYPE,
        CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI
    } iclass_t;

    typedef struct packed {
        logic      pcEnAlways;
        logic      pcEnOnReady;
        logic      pcEnOnZero;
        logic      iorD;
        logic      irWriteOnReady;
        logic      memRead;
        logic      memWrite;
        logic      regWrite;
        memtoreg_t memtoReg;
        srca_t     aluSrcA;
        srcb_t     aluSrcB;
        aluop_t    aluOp;
        pcsrc_t    pcSource;
        logic      illegal;
    } ctrl_t;

    function automatic logic isWaitState(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // Moore control word; the *On* bits are qualified by iMemReady/iZero at the port.
    function automatic ctrl_t stateCtrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memRead        = 1'b1;
                c.irWriteOnReady = 1'b1;
                c.pcEnOnReady    = 1'b1;
                c.aluSrcB        = SRCB_FOUR;
            end
            S_DECODE: c.aluSrcB = SRCB_IMM;
            S_MEMADR: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            S_MEMWB: begin
                c.regWrite = 1'b1;
                c.memtoReg = WB_MDR;
            end
            S_MEMWR: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            S_EXECR: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_RS2;
                c.aluOp   = ALUOP_RFUNCT;
            end
            S_EXECI: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = ALUOP_IFUNCT;
            end
            S_LUI: begin
                c.aluSrcA = SRCA_ZERO;
                c.aluSrcB = SRCB_IMM;
            end
            S_ALUWB: c.regWrite = 1'b1;
            S_BRANCH: begin
                c.aluSrcA    = SRCA_RS1;
                c.aluSrcB    = SRCB_RS2;
                c.aluOp      = ALUOP_SUB;
                c.pcSource   = PCSRC_ALUOUT;
                c.pcEnOnZero = 1'b1;
            end
            S_JAL: begin
                c.regWrite   = 1'b1;
                c.memtoReg   = WB_PC;
                c.pcSource   = PCSRC_ALUOUT;
                c.pcEnAlways = 1'b1;
            end
            S_JALR: begin
                c.aluSrcA    = SRCA_RS1;
                c.aluSrcB    = SRCB_IMM;
                c.regWrite   = 1'b1;
                c.memtoReg   = WB_PC;
                c.pcEnAlways = 1'b1;
            end
            S_ERROR: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_multicycle_control_if.sv
// Control/datapath bundle between the multicycle controller (master) and the datapath.
interface cpu_multicycle_control_if #(parameter int unsigned CNT_W = 32);
    logic [31:0]      iInstruction;
    logic             iMemReady;
    logic             iZero;
    logic             oPCEn;
    logic             oIorD;
    logic             oIRWrite;
    logic             oMemRead;
    logic             oMemWrite;
    logic             oRegWrite;
    logic [1:0]       oMemtoReg;
    logic [1:0]       oALUSrcA;
    logic [1:0]       oALUSrcB;
    logic [1:0]       oALUOp;
    logic [1:0]       oPCSource;
    logic             oIllegal;
    logic [3:0]       oState;
    logic [CNT_W-1:0] oInstrCount;

    modport master (
        input  iInstruction, iMemReady, iZero,
        output oPCEn, oIorD, oIRWrite, oMemRead, oMemWrite, oRegWrite, oMemtoReg,
               oALUSrcA, oALUSrcB, oALUOp, oPCSource, oIllegal, oState, oInstrCount
    );

    modport slave (
        output iInstruction, iMemReady, iZero,
        input  oPCEn, oIorD, oIRWrite, oMemRead, oMemWrite, oRegWrite, oMemtoReg,
               oALUSrcA, oALUSrcB, oALUOp, oPCSource, oIllegal, oState, oInstrCount
    );
endinterface

// File: rtl/cpu_main_decoder.sv
// Combinational RV32I main decoder: classifies the instruction register for the DECODE state.
module cpu_main_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned SUPPORT_LUI = 1
) (
    input  logic [31:0] iInstruction,
    output iclass_t     oClass,
    output logic        oLegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unusedFields;

    assign opcode       = iInstruction[6:0];
    assign funct3       = iInstruction[14:12];
    assign funct7       = iInstruction[31:25];
    assign unusedFields = ^{iInstruction[24:15], iInstruction[11:7]};

    always_comb begin
        oClass = CLS_ILLEGAL;
        case (opcode)
            OP_LOAD:   if (funct3 == F3_LW)   oClass = CLS_LOAD;
            OP_STORE:  if (funct3 == F3_SW)   oClass = CLS_STORE;
            OP_RTYPE:  if (funct7 == F7_BASE || funct7 == F7_ALT) oClass = CLS_RTYPE;
            OP_ITYPE:  oClass = CLS_ITYPE;
            OP_BRANCH: if (funct3 == F3_BEQ)  oClass = CLS_BRANCH;
            OP_JAL:    oClass = CLS_JAL;
            OP_JALR:   if (funct3 == F3_JALR) oClass = CLS_JALR;
            OP_LUI:    if (SUPPORT_LUI != 0)  oClass = CLS_LUI;
            default:   oClass = CLS_ILLEGAL;
        endcase
    end

    assign oLegal = (oClass != CLS_ILLEGAL);

endmodule

// File: rtl/cpu_multicycle_control.sv
// Multicycle RV32I main control: Moore FSM with memory handshake, timeout trap
// and retired-instruction counter.
module cpu_multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned SUPPORT_LUI = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                     iCLK,
    input  logic                     iRST_n,
    cpu_multicycle_control_if.master bus
);

    localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t           state;
    state_t           nextState;
    ctrl_t            ctrl;
    logic [TW-1:0]    waitCnt;
    logic [CNT_W-1:0] instrCount;
    logic             isStore;
    logic             timeoutHit;
    iclass_t          iClass;
    logic             iLegal;

    cpu_main_decoder #(.SUPPORT_LUI(SUPPORT_LUI)) mainDecoder (
        .iInstruction(bus.iInstruction),
        .oClass      (iClass),
        .oLegal      (iLegal)
    );

    // A ready on the last allowed cycle wins over the timeout.
    assign timeoutHit = (MEM_TIMEOUT != 0) && !bus.iMemReady &&
                        (waitCnt == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   nextState = S_FETCH;
            S_FETCH:  if (bus.iMemReady) nextState = S_DECODE;
                      else if (timeoutHit) nextState = S_ERROR;
            S_DECODE: begin
                if (!iLegal) nextState = S_ERROR;
                else begin
                    case (iClass)
                        CLS_LOAD, CLS_STORE: nextState = S_MEMADR;
                        CLS_RTYPE:           nextState = S_EXECR;
                        CLS_ITYPE:           nextState = S_EXECI;
                        CLS_BRANCH:          nextState = S_BRANCH;
                        CLS_JAL:             nextState = S_JAL;
                        CLS_JALR:            nextState = S_JALR;
                        CLS_LUI:             nextState = S_LUI;
                        default:             nextState = S_ERROR;
                    endcase
                end
            end
            S_MEMADR: nextState = isStore ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.iMemReady) nextState = S_MEMWB;
                      else if (timeoutHit) nextState = S_ERROR;
            S_MEMWR:  if (bus.iMemReady) nextState = S_FETCH;
                      else if (timeoutHit) nextState = S_ERROR;
            S_EXECR, S_EXECI, S_LUI: nextState = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR: nextState = S_FETCH;
            S_ERROR:  nextState = S_ERROR;
            default:  nextState = S_ERROR;
        endcase
    end

    // Control word is registered from nextState so it always matches the current state.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= S_IDLE;
            ctrl       <= '0;
            waitCnt    <= '0;
            instrCount <= '0;
            isStore    <= 1'b0;
        end else begin
            state <= nextState;
            ctrl  <= stateCtrl(nextState);
            if (nextState != state && isWaitState(nextState))
                waitCnt <= '0;
            else if (isWaitState(state) && !bus.iMemReady)
                waitCnt <= waitCnt + TW'(1);
            if (nextState == S_FETCH && state != S_FETCH && state != S_IDLE)
                instrCount <= instrCount + CNT_W'(1);
            if (state == S_DECODE)
                isStore <= (iClass == CLS_STORE);
        end
    end

    assign bus.oPCEn       = ctrl.pcEnAlways | (ctrl.pcEnOnReady & bus.iMemReady) |
                             (ctrl.pcEnOnZero & bus.iZero);
    assign bus.oIRWrite    = ctrl.irWriteOnReady & bus.iMemReady;
    assign bus.oIorD       = ctrl.iorD;
    assign bus.oMemRead    = ctrl.memRead;
    assign bus.oMemWrite   = ctrl.memWrite;
    assign bus.oRegWrite   = ctrl.regWrite;
    assign bus.oMemtoReg   = ctrl.memtoReg;
    assign bus.oALUSrcA    = ctrl.aluSrcA;
    assign bus.oALUSrcB    = ctrl.aluSrcB;
    assign bus.oALUOp      = ctrl.aluOp;
    assign bus.oPCSource   = ctrl.pcSource;
    assign bus.oIllegal    = ctrl.illegal;
    assign bus.oState      = state;
    assign bus.oInstrCount = instrCount;

endmodule

// File: doc/cpu_multicycle_control.md
Name: cpu_multicycle_control

Overview:
- Multicycle successor to the single-cycle RV32I main control unit.
- Moore FSM that sequences one instruction over 3–5 cycles. Drives the datapath mux selects, enables and ALUOp.
- Handshakes with a variable-latency memory, detects illegal instructions and memory timeouts, and counts retired instructions.
- Sits between the instruction register and the multicycle datapath in the TopDE CPU.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles for iMemReady. 0 disables the timeout.
- SUPPORT_LUI, 1: 1 means LUI is legal; 0 means LUI traps to ERROR.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- iCLK  in  1  system clock, rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- iInstruction  in  32  current IR contents. Sampled only in DECODE.
- iMemReady  in  1  memory completes the current access this cycle.
- iZero  in  1  ALU zero flag.
- oPCEn  out  1  PC register enable, already combined with iZero for branches.
- oIorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- oIRWrite  out  1  instruction register load.
- oMemRead  out  1  memory read request.
- oMemWrite  out  1  memory write request.
- oRegWrite  out  1  register-file write.
- oMemtoReg  out  2  write-back select: 00 = ALUOut, 01 = MDR, 10 = PC.
- oALUSrcA  out  2  ALU A select: 00 = PC, 01 = rs1, 10 = zero.
- oALUSrcB  out  2  ALU B select: 00 = rs2, 01 = const 4, 10 = imm.
- oALUOp  out  2  00 = add, 01 = sub/branch, 10 = R-funct, 11 = I-funct.
- oPCSource  out  2  next-PC select: 00 = ALU result, 01 = ALUOut.
- oIllegal  out  1  sticky error flag.
- oState  out  4  current state encoding, for debug.
- oInstrCount  out  CNT_W  retired-instruction count.

Behaviour:
- Reset is asynchronous. Asserting iRST_n low at any time, including mid-access, forces IDLE.
- During reset: every output is 0, oInstrCount = 0, the timeout counter is cleared, oState = IDLE.
- All outputs are decoded from state only (Moore), except oPCEn and oIRWrite, which are gated by iZero or iMemReady.
- Any output not listed for a state is 0.
- States and transitions:
  - IDLE: all outputs 0. Next state FETCH.
  - FETCH: oMemRead = 1, oIorD = 0, ALUSrcA = 00, ALUSrcB = 01, ALUOp = 00, PCSource = 00. oIRWrite = oPCEn = iMemReady.
    - Stays in FETCH while iMemReady = 0.
    - Goes to DECODE on iMemReady = 1.
  - DECODE: ALUSrcA = 00, ALUSrcB = 10 (branch/JAL target into ALUOut). Next state by opcode/funct:
    - 0000011 with f3 = 010 → MEMADR (load).
    - 0100011 with f3 = 010 → MEMADR (store).
    - 0110011 with f7 ∈ {0000000, 0100000} → EXECR.
    - 0010011 → EXECI.
    - 1100011 with f3 = 000 → BRANCH.
    - 1101111 → JAL.
    - 1100111 with f3 = 000 → JALR.
    - 0110111 → LUI if SUPPORT_LUI = 1.
    - Anything else → ERROR.
  - MEMADR: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00. Next MEMRD for a load, MEMWR for a store.
  - MEMRD: oMemRead = 1, oIorD = 1. Waits for iMemReady, then MEMWB.
  - MEMWB: oRegWrite = 1, MemtoReg = 01. Next FETCH.
  - MEMWR: oMemWrite = 1, oIorD = 1. Waits for iMemReady, then FETCH.
  - EXECR: ALUSrcA = 01, ALUSrcB = 00, ALUOp = 10. Next ALUWB.
  - EXECI: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 11. Next ALUWB.
  - LUI: ALUSrcA = 10, ALUSrcB = 10, ALUOp = 00. Next ALUWB.
  - ALUWB: oRegWrite = 1, MemtoReg = 00. Next FETCH.
  - BRANCH: ALUSrcA = 01, ALUSrcB = 00, ALUOp = 01, PCSource = 01, oPCEn = iZero. Next FETCH.
  - JAL: oRegWrite = 1, MemtoReg = 10, PCSource = 01, oPCEn = 1. Next FETCH. rd receives the pre-edge PC, which already equals PC+4.
  - JALR: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, PCSource = 00, oPCEn = 1, oRegWrite = 1, MemtoReg = 10. Next FETCH.
  - ERROR: oIllegal = 1, all other controls 0. Held until reset.
- Timeout:
  - The wait counter clears on entry to FETCH, MEMRD or MEMWR.
  - It increments each cycle iMemReady = 0 in those states.
  - If MEM_TIMEOUT > 0, the counter equals MEM_TIMEOUT-1 and iMemReady = 0, the next state is ERROR.
  - iMemReady = 1 on that same cycle wins: normal transition, no error.
- oInstrCount:
  - +1 on every transition into FETCH from any state except IDLE.
  - Wraps modulo 2^CNT_W.
  - Never increments on entry to ERROR.
- Latencies with zero-wait memory (1-cycle ready):
  - Load: 5 cycles.
  - Store, R-type, I-type, LUI: 4 cycles.
  - Branch, JAL, JALR: 3 cycles.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding (4-bit);
  - opcode constants;
  - funct3/funct7 constants;
  - ALUOp, ALUSrcA/B, MemtoReg and PCSource codes.
- The existing single-cycle decoder is to use the same constants.
- One sub-module, cpu_main_decoder: combinational, iInstruction in, instruction class plus legal bit out. Used in DECODE.

Test Plan:
- Reset held low, then released with iMemReady = 1 and IR = 0x00A00093 (addi x1, x0, 10):
  - states IDLE → FETCH → DECODE → EXECI → ALUWB → FETCH;
  - oRegWrite = 1 in ALUWB only;
  - oInstrCount = 1.
- lw 0x0002A303 with iMemReady low for 3 cycles in MEMRD: MEMRD is held 4 cycles, oIorD = 1 throughout, then MEMWB with MemtoReg = 01.
- beq 0x00208463, run twice:
  - iZero = 1 → oPCEn = 1 and PCSource = 01 in BRANCH;
  - iZero = 0 → oPCEn = 0.
- IR = 0xFFFFFFFF, and separately sub with f7 = 0100001: both reach ERROR, oIllegal stays 1 for 20+ cycles, oInstrCount is unchanged.
- MEM_TIMEOUT = 4, iMemReady stuck at 0 in FETCH:
  - ERROR after exactly 4 FETCH cycles;
  - a repeat with iMemReady rising on the 4th cycle reaches DECODE instead.
- iRST_n pulsed low mid-MEMWR: immediately oMemWrite = 0, oState = IDLE, oInstrCount = 0. Then normal restart.
